opb_register_simulink2ppc_bank: RTL and testbench
=================================================

Name: opb_register_simulink2ppc_bank

Overview:
OPB slave that returns Simulink-produced data to the PowerPC. This is the read-back direction of the ppc2simulink software register.
- Fabric logic presents C_NUM_REGS 32-bit words together with a valid strobe.
- The block captures the words and exposes them over OPB with an atomic multi-word snapshot.
- It also provides control and status registers: freeze, update count and overrun.
- The block sits on the OPB bus beside the other software registers. The user side is synchronous to OPB_Clk.

Parameters:
C_BASEADDR, 32'h01000200, first byte address of the block.
C_HIGHADDR, 32'h010002FF, last byte address; decode hit = C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width.
C_NUM_REGS, 4, number of captured data words (1..16).
C_FAMILY, "virtex5", target family (informational).

Ports:
OPB_Clk  in  1  single clock, OPB and user side.
OPB_Rst  in  1  asynchronous, active-high reset.
OPB_ABus  in  [0:31]  address.
OPB_BE  in  [0:3]  byte enables; OPB_BE[0] corresponds to OPB_DBus[0:7].
OPB_DBus  in  [0:31]  write data.
OPB_RNW  in  1  1 = read.
OPB_select  in  1  transfer request.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data.
Sl_errAck  out  1  tied 0.
Sl_retry  out  1  tied 0.
Sl_toutSup  out  1  tied 0.
Sl_xferAck  out  1  transfer acknowledge.
user_data_in  in  [C_NUM_REGS*32-1:0]  word k = bits [32k+31:32k].
user_data_valid  in  1  capture strobe.
user_frozen  out  1  mirror of CTRL.freeze.

Behaviour:
Bit convention:
- Register bit i maps to OPB_DBus/Sl_DBus[31-i].

Address map (byte offsets):
- 0x00 CTRL: read/write; bit0 = freeze; other bits read 0.
- 0x04 STATUS: [15:0] update count, read-only; [16] overrun, sticky; writing 1 to bit16 clears it.
- 0x08+4k DATA k, read-only, for k = 0..C_NUM_REGS-1.
- Writes to DATA are acknowledged and ignored.
- Unmapped in-range offsets are acknowledged and read 0.

Reset values:
- All capture registers, shadow registers, CTRL, count and overrun = 0.
- Sl_xferAck = 0, Sl_DBus = 0, user_frozen = 0.

OPB handshake FSM:
- States IDLE and ACK.
- IDLE → ACK when OPB_select && hit. The address, RNW, BE and DBus are registered at that edge.
- In ACK: Sl_xferAck = 1 for exactly one cycle. Read data is driven on Sl_DBus in that same cycle; Sl_DBus = 0 in all other cycles (OR-bus rule).
- ACK → IDLE unconditionally. This gives at most one ack every 2 cycles.
- Latency: ack occurs 1 cycle after select is sampled high.
- A write takes effect at the ack edge and honours BE; CTRL is only updated when BE[3] = 1.

Capture:
- When user_data_valid && !freeze: all capture regs load user_data_in, and count increments (16-bit, wraps 0xFFFF → 0).
- When user_data_valid && freeze: data is not loaded and overrun is set.
- If a capture and an overrun-clear write land on the same edge, the set wins.

Snapshot:
- An acked read of DATA0 returns capture reg 0 and, on the same edge, copies capture regs 1..N-1 into shadow regs.
- Reads of DATA k≥1 return the shadow register, never the live value.
- When the DATA0 read and a capture coincide, DATA0 returns the pre-capture value and the shadow gets the pre-capture values.

Reset mid-transfer:
- The FSM returns to IDLE immediately and the ack is not issued; the master times out.

Optional Feature:
Macro: SIMULINK2PPC_TIMESTAMP_EN.
With the macro defined:
- A free-running 32-bit cycle counter runs, reset 0, wrapping.
- The counter value is latched on every accepted capture.
- The latched timestamp is included in the DATA0 snapshot shadow.
- It is readable at offset 0x08+4*C_NUM_REGS.
Without the macro:
- The counter and timestamp registers are absent, and that offset reads 0.

Decomposition:
Shared package opb_sw_reg_pkg:
- Offset constants CTRL_OFS, STATUS_OFS, DATA_BASE_OFS.
- FSM state typedef {IDLE, ACK}.
- STATUS bit positions.
Sub-module opb_slave_ack_if:
- Address decode, request registering, IDLE/ACK FSM and Sl_DBus gating.
- Reusable by the other software-register blocks.

Test Plan:
1. Reset: assert OPB_Rst mid-ACK → Sl_xferAck = 0 same cycle. After release, reads of STATUS and all DATA return 0x00000000.
2. Capture + read: drive words 0x11111111..0x44444444 with a 1-cycle valid, then read DATA0..3 → exact values returned, STATUS = 0x00000001, each ack 1 cycle after select.
3. Snapshot atomicity: read DATA0, capture new words 0xAAAA000k, then read DATA1..3 → old values returned. Reading DATA0 again and then DATA1..3 → new values.
4. Freeze/overrun: write CTRL = 1, then pulse valid → data unchanged, count unchanged, STATUS bit16 = 1. Write STATUS 0x00010000 → bit16 clears. Write CTRL = 0 → user_frozen = 0.
5. Wrap: 65536 captures → count = 0x0000. A capture coincident with the overrun-clear write while frozen → overrun remains 1.
6. Bus hygiene: select held high continuously → acks spaced every 2 cycles, Sl_DBus = 0 outside ack. An out-of-range address is never acked.

Source files
------------

// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for the OPB software-register blocks: register offsets,
// status bit positions and the slave handshake state type.
package opb_sw_reg_pkg;

    localparam logic [31:0] CTRL_OFS      = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS    = 32'h0000_0004;
    localparam logic [31:0] DATA_BASE_OFS = 32'h0000_0008;

    localparam int CTRL_FREEZE_BIT    = 0;
    localparam int STATUS_COUNT_W     = 16;
    localparam int STATUS_OVERRUN_BIT = 16;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } opb_state_t;

endpackage

// File: rtl/opb_slave_ack_if.sv
// OPB slave front end: address decode, request capture, IDLE/ACK handshake
// and OR-bus gating of read data. Shared by the software-register blocks.
module opb_slave_ack_if
    import opb_sw_reg_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter int                      C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_0200,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_02FF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [0:C_OPB_AWIDTH-1]     opb_abus,
    input  logic [0:C_OPB_DWIDTH/8-1]   opb_be,
    input  logic [0:C_OPB_DWIDTH-1]     opb_dbus,
    input  logic                        opb_rnw,
    input  logic                        opb_select,
    input  logic [C_OPB_DWIDTH-1:0]     rd_data,
    output logic [C_OPB_AWIDTH-1:0]     req_ofs,
    output logic [C_OPB_DWIDTH/8-1:0]   req_be,
    output logic [C_OPB_DWIDTH-1:0]     req_wdata,
    output logic                        wr_stb,
    output logic                        rd_stb,
    output logic [0:C_OPB_DWIDTH-1]     sl_dbus,
    output logic                        sl_xferack
);

    opb_state_t                 state_q;
    opb_state_t                 state_d;
    logic [C_OPB_AWIDTH-1:0]    addr;
    logic                       hit;
    logic                       req_rnw;

    // Whole-vector assignment turns the big-endian bus into LSB-0 numbering.
    assign addr = opb_abus;
    assign hit  = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ofs   <= '0;
            req_be    <= '0;
            req_wdata <= '0;
            req_rnw   <= 1'b0;
        end else if (state_q == IDLE && opb_select && hit) begin
            req_ofs   <= addr - C_BASEADDR;
            req_be    <= opb_be;
            req_wdata <= opb_dbus;
            req_rnw   <= opb_rnw;
        end
    end

    always_comb begin
        state_d    = state_q;
        sl_xferack = 1'b0;
        wr_stb     = 1'b0;
        rd_stb     = 1'b0;
        sl_dbus    = '0;
        case (state_q)
            IDLE: begin
                if (opb_select && hit) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d    = IDLE;
                sl_xferack = 1'b1;
                wr_stb     = !req_rnw;
                rd_stb     = req_rnw;
                if (req_rnw) begin
                    sl_dbus = rd_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/opb_register_simulink2ppc_bank.sv
// OPB read-back bank: captures C_NUM_REGS fabric words and serves them with an
// atomic DATA0-triggered snapshot. Define SIMULINK2PPC_TIMESTAMP_EN for a capture timestamp.
module opb_register_simulink2ppc_bank
    import opb_sw_reg_pkg::*;
#(
    parameter int                      C_OPB_AWIDTH = 32,
    parameter int                      C_OPB_DWIDTH = 32,
    parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = 32'h0100_0200,
    parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = 32'h0100_02FF,
    parameter int                      C_NUM_REGS   = 4,
    parameter string                   C_FAMILY     = "virtex5"
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic                        Sl_xferAck,
    input  logic [C_NUM_REGS*32-1:0]    user_data_in,
    input  logic                        user_data_valid,
    output logic                        user_frozen
);

    localparam string       family_unused = C_FAMILY;
    localparam logic [31:0] DATA_END_OFS  = DATA_BASE_OFS + 32'(4 * C_NUM_REGS);

    logic [C_OPB_AWIDTH-1:0]   req_ofs;
    logic [3:0]                req_be;
    logic [31:0]               req_wdata;
    logic                      wr_stb;
    logic                      rd_stb;
    logic [31:0]               rd_data;
    logic [31:0]               ofs_al;
    logic [31:0]               data_idx;

    logic [31:0]               cap_q    [C_NUM_REGS];
    logic [31:0]               shadow_q [C_NUM_REGS];
    logic                      freeze_q;
    logic                      overrun_q;
    logic [STATUS_COUNT_W-1:0] count_q;

    logic                      wr_ctrl;
    logic                      clr_overrun;
    logic                      rd_data0;
    logic                      capture;
    logic                      unused_ok;

    opb_slave_ack_if #(
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_OPB_DWIDTH (C_OPB_DWIDTH),
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR)
    ) u_ack_if (
        .clk        (OPB_Clk),
        .rst        (OPB_Rst),
        .opb_abus   (OPB_ABus),
        .opb_be     (OPB_BE),
        .opb_dbus   (OPB_DBus),
        .opb_rnw    (OPB_RNW),
        .opb_select (OPB_select),
        .rd_data    (rd_data),
        .req_ofs    (req_ofs),
        .req_be     (req_be),
        .req_wdata  (req_wdata),
        .wr_stb     (wr_stb),
        .rd_stb     (rd_stb),
        .sl_dbus    (Sl_DBus),
        .sl_xferack (Sl_xferAck)
    );

    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_frozen = freeze_q;
    assign unused_ok   = ^{OPB_seqAddr, req_ofs[1:0], req_wdata};

    // req_be[j] enables register byte j (req_be[0] = OPB_BE[3] = bits 7:0).
    assign ofs_al      = {req_ofs[31:2], 2'b00};
    assign data_idx    = (ofs_al - DATA_BASE_OFS) >> 2;
    assign wr_ctrl     = wr_stb && (ofs_al == CTRL_OFS) && req_be[0];
    assign clr_overrun = wr_stb && (ofs_al == STATUS_OFS) && req_be[2]
                         && req_wdata[STATUS_OVERRUN_BIT];
    assign rd_data0    = rd_stb && (ofs_al == DATA_BASE_OFS);
    assign capture     = user_data_valid && !freeze_q;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                cap_q[k] <= '0;
            end
            count_q <= '0;
        end else if (capture) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                cap_q[k] <= user_data_in[32*k +: 32];
            end
            count_q <= count_q + 1'b1;
        end
    end

    // A frozen capture raising overrun outranks a coincident clear.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            freeze_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                freeze_q <= req_wdata[CTRL_FREEZE_BIT];
            end
            if (user_data_valid && freeze_q) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // Shadow takes the pre-capture values when a capture lands on the same edge.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (rd_data0) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                shadow_q[k] <= cap_q[k];
            end
        end
    end

`ifdef SIMULINK2PPC_TIMESTAMP_EN
    logic [31:0] ts_cnt_q;
    logic [31:0] ts_cap_q;
    logic [31:0] ts_shadow_q;

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            ts_cnt_q    <= '0;
            ts_cap_q    <= '0;
            ts_shadow_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + 32'd1;
            if (capture) begin
                ts_cap_q <= ts_cnt_q;
            end
            if (rd_data0) begin
                ts_shadow_q <= ts_cap_q;
            end
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (ofs_al == CTRL_OFS) begin
            rd_data[CTRL_FREEZE_BIT] = freeze_q;
        end else if (ofs_al == STATUS_OFS) begin
            rd_data[STATUS_COUNT_W-1:0]  = count_q;
            rd_data[STATUS_OVERRUN_BIT]  = overrun_q;
        end else if (ofs_al >= DATA_BASE_OFS && ofs_al < DATA_END_OFS) begin
            rd_data = cap_q[0];
            for (int k = 1; k < C_NUM_REGS; k++) begin
                if (data_idx == 32'(k)) begin
                    rd_data = shadow_q[k];
                end
            end
`ifdef SIMULINK2PPC_TIMESTAMP_EN
        end else if (ofs_al == DATA_END_OFS) begin
            rd_data = ts_shadow_q;
`endif
        end
    end

endmodule

// File: tb/tb_opb_register_simulink2ppc_bank.sv
// Randomised scoreboard bench for opb_register_simulink2ppc_bank against a
// register-level behavioural model.
module tb_opb_register_simulink2ppc_bank;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0100_0200;

    logic            OPB_Clk = 1'b0;
    logic            OPB_Rst;
    logic [0:31]     OPB_ABus;
    logic [0:3]      OPB_BE;
    logic [0:31]     OPB_DBus;
    logic            OPB_RNW;
    logic            OPB_select;
    logic            OPB_seqAddr;
    logic [0:31]     Sl_DBus;
    logic            Sl_errAck;
    logic            Sl_retry;
    logic            Sl_toutSup;
    logic            Sl_xferAck;
    logic [N*32-1:0] user_data_in;
    logic            user_data_valid;
    logic            user_frozen;

    opb_register_simulink2ppc_bank #(.C_NUM_REGS(N)) dut (
        .OPB_Clk         (OPB_Clk),
        .OPB_Rst         (OPB_Rst),
        .OPB_ABus        (OPB_ABus),
        .OPB_BE          (OPB_BE),
        .OPB_DBus        (OPB_DBus),
        .OPB_RNW         (OPB_RNW),
        .OPB_select      (OPB_select),
        .OPB_seqAddr     (OPB_seqAddr),
        .Sl_DBus         (Sl_DBus),
        .Sl_errAck       (Sl_errAck),
        .Sl_retry        (Sl_retry),
        .Sl_toutSup      (Sl_toutSup),
        .Sl_xferAck      (Sl_xferAck),
        .user_data_in    (user_data_in),
        .user_data_valid (user_data_valid),
        .user_frozen     (user_frozen)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;

    typedef struct {
        logic        rnw;
        logic [31:0] exp;
        string       nm;
    } sb_t;
    sb_t sb_q[$];

    // Behavioural model: register contents as the software sees them.
    logic [31:0] m_cap    [N];
    logic [31:0] m_shadow [N];
    logic        m_freeze;
    logic        m_ovr;
    logic [15:0] m_count;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int j = 0; j < N; j++) begin
            m_cap[j]    = '0;
            m_shadow[j] = '0;
        end
        m_freeze = 1'b0;
        m_ovr    = 1'b0;
        m_count  = '0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] ofs);
        logic [31:0] a;
        int          k;
        a = {ofs[31:2], 2'b00};
        if (a == 32'h0) return {31'b0, m_freeze};
        if (a == 32'h4) return {15'b0, m_ovr, m_count};
        if (a >= 32'h8 && a < 32'h8 + 4 * N) begin
            k = int'((a - 32'h8) / 4);
            if (k == 0) begin
                for (int j = 0; j < N; j++) m_shadow[j] = m_cap[j];
                return m_cap[0];
            end
            return m_shadow[k];
        end
        return 32'h0;
    endfunction

    function automatic void m_write(input logic [31:0] ofs, input logic [0:3] be, input logic [31:0] wd);
        logic [31:0] a;
        a = {ofs[31:2], 2'b00};
        if (a == 32'h0 && be[3]) m_freeze = wd[0];
        if (a == 32'h4 && be[1] && wd[16]) m_ovr = 1'b0;
    endfunction

    function automatic void m_capture(input logic [N*32-1:0] d, input logic frz);
        if (frz) begin
            m_ovr = 1'b1;
        end else begin
            for (int j = 0; j < N; j++) m_cap[j] = d[32*j +: 32];
            m_count = m_count + 16'd1;
        end
    endfunction

    function automatic logic [N*32-1:0] rand_words();
        logic [N*32-1:0] d;
        for (int j = 0; j < N; j++) d[32*j +: 32] = $urandom;
        return d;
    endfunction

    // One OPB transfer; optionally a capture is presented on the ack edge.
    task automatic bus_op(input logic rnw, input logic [31:0] ofs, input logic [0:3] be,
                          input logic [31:0] wd, input logic cap_en,
                          input logic [N*32-1:0] cap_data, input string nm);
        logic [31:0] exp;
        logic        frz;
        sb_t         e;
        @(negedge OPB_Clk);
        OPB_ABus   = BASE + ofs;
        OPB_RNW    = rnw;
        OPB_BE     = be;
        OPB_DBus   = wd;
        OPB_select = 1'b1;
        frz = m_freeze;
        exp = 32'h0;
        if (rnw) exp = m_read(ofs);
        else     m_write(ofs, be, wd);
        if (cap_en) m_capture(cap_data, frz);
        e.rnw = rnw; e.exp = exp; e.nm = nm;
        sb_q.push_back(e);
        @(posedge OPB_Clk);
        #1;
        OPB_select = 1'b0;
        if (cap_en) begin
            user_data_in    = cap_data;
            user_data_valid = 1'b1;
        end
        @(negedge OPB_Clk);
        check({nm, "_ack_latency"}, {31'b0, Sl_xferAck}, 32'h1);
        @(posedge OPB_Clk);
        #1;
        user_data_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] ofs, input string nm);
        bus_op(1'b1, ofs, 4'hF, 32'h0, 1'b0, '0, nm);
    endtask

    task automatic wr(input logic [31:0] ofs, input logic [0:3] be, input logic [31:0] wd, input string nm);
        bus_op(1'b0, ofs, be, wd, 1'b0, '0, nm);
    endtask

    task automatic cap(input logic [N*32-1:0] d);
        @(negedge OPB_Clk);
        user_data_in    = d;
        user_data_valid = 1'b1;
        m_capture(d, m_freeze);
        @(posedge OPB_Clk);
        #1;
        user_data_valid = 1'b0;
    endtask

    task automatic read_all(input string tag);
        rd(32'h4, {tag, "_status"});
        for (int k = 0; k < N; k++) rd(32'h8 + 4 * k, $sformatf("%s_data%0d", tag, k));
    endtask

    task automatic pulse_reset();
        @(negedge OPB_Clk);
        OPB_Rst = 1'b1;
        m_reset();
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
    endtask

    // Monitor: every ack pops one expectation; no data may appear outside an ack.
    initial begin
        sb_t e;
        forever begin
            @(negedge OPB_Clk);
            if (!OPB_Rst) begin
                if (Sl_xferAck) begin
                    ack_cnt++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_ack", 32'h1, 32'h0);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.rnw) check(e.nm, Sl_DBus, e.exp);
                        else       check({e.nm, "_wr_dbus"}, Sl_DBus, 32'h0);
                    end
                end else if (Sl_DBus !== 32'h0) begin
                    check("dbus_idle", Sl_DBus, 32'h0);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*32-1:0] d;
        logic [5:0]      pattern;
        int              acks_before;
        int              op;
        logic [31:0]     ofs;

        OPB_Rst = 1'b1;
        OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0; OPB_RNW = 1'b0;
        OPB_select = 1'b0; OPB_seqAddr = 1'b0;
        user_data_in = '0; user_data_valid = 1'b0;
        m_reset();
        repeat (3) @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        @(negedge OPB_Clk);
        check("rst_xferack", {31'b0, Sl_xferAck}, 32'h0);
        check("rst_dbus", Sl_DBus, 32'h0);
        check("rst_frozen", {31'b0, user_frozen}, 32'h0);
        check("rst_tied", {29'b0, Sl_errAck, Sl_retry, Sl_toutSup}, 32'h0);

        // Reset landing in the ACK cycle kills the ack immediately.
        cap(rand_words());
        @(negedge OPB_Clk);
        OPB_ABus = BASE + 32'h4; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
        @(posedge OPB_Clk);
        #1;
        OPB_select = 1'b0;
        check("midack_ack_before", {31'b0, Sl_xferAck}, 32'h1);
        OPB_Rst = 1'b1;
        #1;
        check("midack_ack_killed", {31'b0, Sl_xferAck}, 32'h0);
        check("midack_dbus", Sl_DBus, 32'h0);
        m_reset();
        @(negedge OPB_Clk);
        OPB_Rst = 1'b0;
        read_all("post_rst");
        rd(32'h0, "post_rst_ctrl");

        for (int k = 0; k < N; k++) d[32*k +: 32] = 32'h1111_1111 * (k + 1);
        cap(d);
        read_all("capture");

        rd(32'h8, "snap_data0_a");
        for (int k = 0; k < N; k++) d[32*k +: 32] = 32'hAAAA_0000 + k;
        cap(d);
        for (int k = 1; k < N; k++) rd(32'h8 + 4 * k, $sformatf("snap_old%0d", k));
        read_all("snap_new");

        wr(32'h0, 4'hF, 32'h1, "freeze_on");
        check("frozen_on", {31'b0, user_frozen}, 32'h1);
        cap(rand_words());
        read_all("frozen");
        wr(32'h4, 4'hF, 32'h0001_0000, "ovr_clr");
        rd(32'h4, "ovr_cleared");
        wr(32'h0, 4'b1110, 32'h0, "ctrl_no_be3");
        check("frozen_kept", {31'b0, user_frozen}, 32'h1);
        wr(32'h0, 4'hF, 32'h0, "freeze_off");
        check("frozen_off", {31'b0, user_frozen}, 32'h0);
        wr(32'h8, 4'hF, 32'hDEAD_BEEF, "data_wr_ignored");
        rd(32'h8, "data0_after_wr");
        rd(32'h80, "unmapped");
`ifndef SIMULINK2PPC_TIMESTAMP_EN
        rd(32'h8 + 4 * N, "ts_absent");
`endif

        // Capture coincident with a DATA0 read: old values returned and shadowed.
        bus_op(1'b1, 32'h8, 4'hF, 32'h0, 1'b1, rand_words(), "coinc_data0");
        for (int k = 1; k < N; k++) rd(32'h8 + 4 * k, $sformatf("coinc_shadow%0d", k));

        // Select held high: acks on alternating cycles.
        @(negedge OPB_Clk);
        OPB_ABus = BASE; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sb_t e;
            e.rnw = 1'b1; e.exp = m_read(32'h0); e.nm = $sformatf("held_sel%0d", i);
            sb_q.push_back(e);
        end
        pattern = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge OPB_Clk);
            pattern = {pattern[4:0], Sl_xferAck};
        end
        OPB_select = 1'b0;
        check("held_sel_pattern", {26'b0, pattern}, 32'h2A);

        acks_before = ack_cnt;
        foreach (sb_q[i]) begin end
        @(negedge OPB_Clk);
        OPB_ABus = BASE + 32'h100; OPB_RNW = 1'b1; OPB_select = 1'b1;
        repeat (4) @(negedge OPB_Clk);
        OPB_ABus = BASE - 32'h4;
        repeat (4) @(negedge OPB_Clk);
        OPB_select = 1'b0;
        @(negedge OPB_Clk);
        check("out_of_range_acks", 32'(ack_cnt - acks_before), 32'h0);

        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(0, 6));
            ofs = 32'($urandom_range(0, 63)) * 4;
`ifdef SIMULINK2PPC_TIMESTAMP_EN
            if (ofs == 32'h8 + 4 * N) ofs = 32'h0;
`endif
            case (op)
                0, 1: cap(rand_words());
                2:    rd(ofs, $sformatf("rnd%0d_rd", i));
                3:    rd(32'h8 + 4 * $urandom_range(0, N - 1), $sformatf("rnd%0d_data", i));
                4:    wr(32'h0, 4'($urandom), $urandom, $sformatf("rnd%0d_ctrl", i));
                5:    bus_op(1'b0, 32'h4, 4'($urandom), $urandom, 1'($urandom),
                             rand_words(), $sformatf("rnd%0d_stat", i));
                default: bus_op(1'b1, ofs, 4'hF, 32'h0, 1'b1, rand_words(),
                                $sformatf("rnd%0d_rdcap", i));
            endcase
        end
        read_all("rnd_end");

        // Count wrap and set-wins-over-clear.
        pulse_reset();
        wr(32'h0, 4'hF, 32'h0, "wrap_unfreeze");
        d = rand_words();
        @(negedge OPB_Clk);
        user_data_in = d;
        user_data_valid = 1'b1;
        for (int i = 0; i < 65536; i++) m_capture(d, 1'b0);
        repeat (65536) @(posedge OPB_Clk);
        #1;
        user_data_valid = 1'b0;
        read_all("wrap");
        check("wrap_model_count", {16'b0, m_count}, 32'h0);
        wr(32'h0, 4'hF, 32'h1, "wrap_freeze");
        cap(rand_words());
        bus_op(1'b0, 32'h4, 4'hF, 32'h0001_0000, 1'b1, rand_words(), "setwins_clr");
        rd(32'h4, "setwins_status");

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge OPB_Clk);
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
